mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the CPU's instruction-fetch requester (IF) and its data

---
 rtl/mem_arb_pkg.sv | 40 ++++
 rtl/mem_arb_wait_cnt.sv | 32 +++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state encoding,
// owner encoding and the arbitration helper used on simultaneous requests.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Pick the next owner from the two request lines. With rr_en set, a tie
    // goes to whichever requester did not own the previous access; otherwise
    // the data port always wins a tie.
    function automatic owner_t pick_owner(
        input logic   if_req,
        input logic   d_req,
        input owner_t last_owner,
        input bit     rr_en
    );
        owner_t sel;
        if (if_req && d_req) begin
            if (rr_en) begin
                sel = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
            end else begin
                sel = OWN_D;
            end
        end else if (d_req) begin
            sel = OWN_D;
        end else begin
            sel = OWN_IF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Loadable down-counter with a zero flag; times the ACCESS phase of the
// memory port arbiter. Saturates at zero.
module mem_arb_wait_cnt #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Zero flag marks the last ACCESS cycle.
    always_comb begin
        zero = (cnt == '0);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch requester (IF)
// and the data load/store requester (D). Each access is IDLE -> ACCESS
// (MEM_LAT cycles) -> RESP, with a one-cycle grant pulse at launch and a
// one-cycle valid pulse in RESP.
// Build option: define MEM_ARB_RR_EN for round-robin on simultaneous
// requests; otherwise the data port has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam int unsigned CW = $clog2(MEM_LAT) + 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(MEM_LAT - 1);

    arb_state_t state;
    arb_state_t state_n;
    owner_t     owner;
    owner_t     last_owner;
    owner_t     grant_owner;
    logic       cap_we;
    logic       launch;
    logic       finish;
    logic       wait_zero;

    mem_arb_wait_cnt #(
        .W (CW)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (launch),
        .load_val (WAIT_LOAD),
        .dec      (state == ACCESS),
        .zero     (wait_zero)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, launch/finish strobes, arbitration and busy.
    always_comb begin
        state_n     = state;
        launch      = 1'b0;
        finish      = 1'b0;
        grant_owner = pick_owner(if_req, d_req, last_owner, RR_EN);
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    state_n = ACCESS;
                    launch  = 1'b1;
                end
            end
            ACCESS: begin
                if (wait_zero) begin
                    state_n = RESP;
                    finish  = 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Launch: capture the winner's request and pulse grant/mem_en for one cycle.
    // Address and write data stay in the capture registers so requester
    // changes during ACCESS cannot reach the memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            cap_we     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if_gnt <= 1'b0;
            d_gnt  <= 1'b0;
            if (launch) begin
                owner      <= grant_owner;
                last_owner <= grant_owner;
                mem_en     <= 1'b1;
                if (grant_owner == OWN_D) begin
                    cap_we    <= d_we;
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    d_gnt     <= 1'b1;
                end else begin
                    cap_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    if_gnt    <= 1'b1;
                end
            end
        end
    end

    // Completion: latch read data on the last ACCESS cycle and pulse valid in RESP.
    // Stores leave d_rdata untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (finish) begin
                if (owner == OWN_IF) begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_rdata;
                end else begin
                    d_valid <= 1'b1;
                    if (!cap_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: two instances (MEM_LAT=1 and 3),
// directed scenarios plus randomized traffic against a cycle-count model.
module tb_mem_port_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_valid  [2];
    logic [31:0] if_rdata  [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_gnt     [2];
    logic        d_valid   [2];
    logic [31:0] d_rdata   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    int unsigned total = 0;
    int unsigned bad   = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT0)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_valid(d_valid[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT1)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_valid(d_valid[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    // Memory contents: explicit entries, otherwise an address hash.
    logic [31:0] mem_img [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    // Control outputs packed as {if_gnt,d_gnt,if_valid,d_valid,mem_en,mem_we,busy}.
    function automatic logic [6:0] ctrl(input int i);
        return {if_gnt[i], d_gnt[i], if_valid[i], d_valid[i], mem_en[i], mem_we[i], busy[i]};
    endfunction

    // Memory with MEM_LAT latency: read data is only meaningful in the last
    // access cycle; any other cycle carries random garbage.
    int k_cnt [2];
    bit k_act [2];
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i] === 1'b1) begin
                k_act[i] = 1'b1;
                k_cnt[i] = 0;
                if (mem_we[i] === 1'b1) mem_img[mem_addr[i]] = mem_wdata[i];
            end else if (k_act[i]) begin
                k_cnt[i] = k_cnt[i] + 1;
            end
            if (k_act[i] && k_cnt[i] == lat_of(i) - 1) begin
                mem_rdata[i] = mem_read(mem_addr[i]);
                k_act[i] = 1'b0;
            end else begin
                mem_rdata[i] = $urandom;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ctrl(i) !== 7'b0) begin
                bad++;
                $display("FAIL reset_ctrl[%0d]: got %b expected 0000000", i, ctrl(i));
            end
            total++;
            if ({if_rdata[i], d_rdata[i], mem_addr[i], mem_wdata[i]} !== 128'b0) begin
                bad++;
                $display("FAIL reset_data[%0d]: if_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h expected all 0",
                         i, if_rdata[i], d_rdata[i], mem_addr[i], mem_wdata[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        mem_img[32'h40] = 32'hDEADBEEF;
        @(negedge clk);
        if_addr[0] = 32'h40;
        if_req[0]  = 1'b1;
        @(negedge clk);
        total++;
        if (ctrl(0) !== 7'b1000101) begin
            bad++; $display("FAIL fetch_launch: got %b expected 1000101", ctrl(0));
        end
        total++;
        if (mem_addr[0] !== 32'h40) begin
            bad++; $display("FAIL fetch_addr: got %h expected 00000040", mem_addr[0]);
        end
        @(negedge clk);
        total++;
        if (ctrl(0) !== 7'b0010001) begin
            bad++; $display("FAIL fetch_valid: got %b expected 0010001", ctrl(0));
        end
        total++;
        if (if_rdata[0] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL fetch_rdata: got %h expected deadbeef", if_rdata[0]);
        end
        if_req[0] = 1'b0;
        @(negedge clk);
        total++;
        if (ctrl(0) !== 7'b0) begin
            bad++; $display("FAIL fetch_idle: got %b expected 0000000", ctrl(0));
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        d_we[1]    = 1'b1;
        d_addr[1]  = 32'h100;
        d_wdata[1] = 32'h12345678;
        d_req[1]   = 1'b1;
        @(negedge clk);
        total++;
        if (ctrl(1) !== 7'b0100111) begin
            bad++; $display("FAIL store_launch: got %b expected 0100111", ctrl(1));
        end
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin
                total++;
                if (ctrl(1) !== 7'b0000001) begin
                    bad++; $display("FAIL store_wait%0d: got %b expected 0000001", c, ctrl(1));
                end
            end
            total++;
            if (mem_addr[1] !== 32'h100 || mem_wdata[1] !== 32'h12345678) begin
                bad++;
                $display("FAIL store_hold%0d: addr=%h wdata=%h expected 00000100 12345678",
                         c, mem_addr[1], mem_wdata[1]);
            end
            @(negedge clk);
        end
        total++;
        if (ctrl(1) !== 7'b0001001) begin
            bad++; $display("FAIL store_valid: got %b expected 0001001", ctrl(1));
        end
        total++;
        if (d_rdata[1] !== 32'h0) begin
            bad++; $display("FAIL store_rdata: got %h expected 00000000", d_rdata[1]);
        end
        d_req[1] = 1'b0;
        d_we[1]  = 1'b0;
        @(negedge clk);
        total++;
        if (ctrl(1) !== 7'b0) begin
            bad++; $display("FAIL store_idle: got %b expected 0000000", ctrl(1));
        end
    endtask

    task automatic test_simultaneous();
        bit fd;
`ifdef MEM_ARB_RR_EN
        fd = 1'b0;
`else
        fd = 1'b1;
`endif
        // Warm-up data load so the previous owner is D.
        @(negedge clk);
        d_we[0] = 1'b0; d_addr[0] = 32'h80; d_req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (d_valid[0] !== 1'b1 || d_rdata[0] !== mem_read(32'h80)) begin
            bad++;
            $display("FAIL sim_warmup: valid=%b rdata=%h expected 1 %h", d_valid[0], d_rdata[0], mem_read(32'h80));
        end
        d_req[0] = 1'b0;
        @(negedge clk);
        if_addr[0] = 32'h44; if_req[0] = 1'b1;
        d_addr[0]  = 32'h84; d_req[0]  = 1'b1;
        @(negedge clk);
        total++;
        if (ctrl(0) !== {~fd, fd, 5'b00101}) begin
            bad++; $display("FAIL sim_first_gnt: got %b expected %b", ctrl(0), {~fd, fd, 5'b00101});
        end
        @(negedge clk);
        total++;
        if (ctrl(0) !== {2'b00, ~fd, fd, 3'b001}) begin
            bad++; $display("FAIL sim_first_valid: got %b expected %b", ctrl(0), {2'b00, ~fd, fd, 3'b001});
        end
        if (fd) d_req[0] = 1'b0; else if_req[0] = 1'b0;
        @(negedge clk);
        total++;
        if (ctrl(0) !== 7'b0) begin
            bad++; $display("FAIL sim_gap: got %b expected 0000000", ctrl(0));
        end
        @(negedge clk);
        total++;
        if (ctrl(0) !== {fd, ~fd, 5'b00101}) begin
            bad++; $display("FAIL sim_second_gnt: got %b expected %b", ctrl(0), {fd, ~fd, 5'b00101});
        end
        @(negedge clk);
        total++;
        if (ctrl(0) !== {2'b00, fd, ~fd, 3'b001}) begin
            bad++; $display("FAIL sim_second_valid: got %b expected %b", ctrl(0), {2'b00, fd, ~fd, 3'b001});
        end
        total++;
        if (if_rdata[0] !== mem_read(32'h44) || d_rdata[0] !== mem_read(32'h84)) begin
            bad++;
            $display("FAIL sim_rdata: if=%h d=%h expected %h %h",
                     if_rdata[0], d_rdata[0], mem_read(32'h44), mem_read(32'h84));
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_we[1] = 1'b0; d_addr[1] = 32'h200; d_req[1] = 1'b1;
        @(negedge clk);
        total++;
        if (ctrl(1) !== 7'b0100101) begin
            bad++; $display("FAIL rstmid_launch: got %b expected 0100101", ctrl(1));
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ctrl(i) !== 7'b0 || if_rdata[i] !== 32'h0 || d_rdata[i] !== 32'h0 || mem_addr[i] !== 32'h0) begin
                bad++;
                $display("FAIL rstmid_zero[%0d]: ctrl=%b if_rdata=%h d_rdata=%h mem_addr=%h expected all 0",
                         i, ctrl(i), if_rdata[i], d_rdata[i], mem_addr[i]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (ctrl(1) !== 7'b0100101 || mem_addr[1] !== 32'h200) begin
            bad++; $display("FAIL rstmid_regrant: ctrl=%b addr=%h expected 0100101 00000200", ctrl(1), mem_addr[1]);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (ctrl(1) !== 7'b0000001) begin
                bad++; $display("FAIL rstmid_wait%0d: got %b expected 0000001", c, ctrl(1));
            end
        end
        @(negedge clk);
        total++;
        if (ctrl(1) !== 7'b0001001 || d_rdata[1] !== mem_read(32'h200)) begin
            bad++;
            $display("FAIL rstmid_valid: ctrl=%b rdata=%h expected 0001001 %h", ctrl(1), d_rdata[1], mem_read(32'h200));
        end
        d_req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_change();
        @(negedge clk);
        if_addr[1] = 32'h300; if_req[1] = 1'b1;
        @(negedge clk);
        total++;
        if (ctrl(1) !== 7'b1000101 || mem_addr[1] !== 32'h300) begin
            bad++; $display("FAIL addrchg_launch: ctrl=%b addr=%h expected 1000101 00000300", ctrl(1), mem_addr[1]);
        end
        if_addr[1] = 32'h3F0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (ctrl(1) !== 7'b0000001 || mem_addr[1] !== 32'h300) begin
                bad++;
                $display("FAIL addrchg_hold%0d: ctrl=%b addr=%h expected 0000001 00000300", c, ctrl(1), mem_addr[1]);
            end
        end
        @(negedge clk);
        total++;
        if (ctrl(1) !== 7'b0010001 || if_rdata[1] !== mem_read(32'h300)) begin
            bad++;
            $display("FAIL addrchg_valid: ctrl=%b rdata=%h expected 0010001 %h", ctrl(1), if_rdata[1], mem_read(32'h300));
        end
        // Request stays high through RESP and is dropped at the start of IDLE.
        @(posedge clk);
        #1 if_req[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (ctrl(1) !== 7'b0) begin
                bad++; $display("FAIL addrchg_nogrant%0d: got %b expected 0000000", c, ctrl(1));
            end
        end
    endtask

    task automatic test_random(input int idx, input int ncyc);
        int          lat;
        int          phase;
        bit          is_d;
        bit          last_d;
        bit          cap_we;
        logic [31:0] cap_addr;
        logic [31:0] cap_wdata;
        logic [31:0] exp_if;
        logic [31:0] exp_d;
        logic [6:0]  exp_ctrl;
        bit          en;
        lat = lat_of(idx);
        @(negedge clk);
        reset = 1'b1;
        if_req[idx] = 1'b0; d_req[idx] = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        phase  = 0; is_d = 1'b0; last_d = 1'b0; cap_we = 1'b0;
        cap_addr = '0; cap_wdata = '0; exp_if = '0; exp_d = '0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            en = (phase == 1);
            exp_ctrl = {en && !is_d, en && is_d, (phase == lat + 1) && !is_d, (phase == lat + 1) && is_d,
                        en, en && is_d && cap_we, phase != 0};
            total++;
            if (ctrl(idx) !== exp_ctrl) begin
                bad++; $display("FAIL rand%0d_ctrl cyc%0d: got %b expected %b", idx, cyc, ctrl(idx), exp_ctrl);
            end
            if (phase >= 1 && phase <= lat) begin
                total++;
                if (mem_addr[idx] !== cap_addr || (is_d && cap_we && mem_wdata[idx] !== cap_wdata)) begin
                    bad++;
                    $display("FAIL rand%0d_bus cyc%0d: addr=%h wdata=%h expected %h %h",
                             idx, cyc, mem_addr[idx], mem_wdata[idx], cap_addr, cap_wdata);
                end
            end
            total++;
            if (if_rdata[idx] !== exp_if || d_rdata[idx] !== exp_d) begin
                bad++;
                $display("FAIL rand%0d_rdata cyc%0d: if=%h d=%h expected %h %h",
                         idx, cyc, if_rdata[idx], d_rdata[idx], exp_if, exp_d);
            end
            // Requesters: hold until valid, then drop or chain a new request.
            if (if_req[idx] && if_valid[idx]) begin
                if ($urandom_range(0, 3) == 0) if_addr[idx] = 32'($urandom_range(0, 15)) << 2;
                else if_req[idx] = 1'b0;
            end else if (!if_req[idx] && $urandom_range(0, 2) == 0) begin
                if_addr[idx] = 32'($urandom_range(0, 15)) << 2;
                if_req[idx]  = 1'b1;
            end
            if (d_req[idx] && d_valid[idx]) begin
                d_req[idx] = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    d_we[idx] = 1'($urandom_range(0, 1)); d_wdata[idx] = $urandom;
                    d_addr[idx] = 32'($urandom_range(0, 15)) << 2; d_req[idx] = 1'b1;
                end
            end else if (!d_req[idx] && $urandom_range(0, 2) == 0) begin
                d_we[idx] = 1'($urandom_range(0, 1)); d_wdata[idx] = $urandom;
                d_addr[idx] = 32'($urandom_range(0, 15)) << 2; d_req[idx] = 1'b1;
            end
            @(posedge clk);
            // Model: each access occupies lat+2 cycles from launch to back in IDLE.
            if (phase == 0) begin
                if (if_req[idx] || d_req[idx]) begin
`ifdef MEM_ARB_RR_EN
                    is_d = (if_req[idx] && d_req[idx]) ? !last_d : d_req[idx];
`else
                    is_d = d_req[idx];
`endif
                    last_d    = is_d;
                    cap_we    = is_d && d_we[idx];
                    cap_addr  = is_d ? d_addr[idx] : if_addr[idx];
                    cap_wdata = d_wdata[idx];
                    phase     = 1;
                end
            end else if (phase == lat + 1) begin
                phase = 0;
            end else begin
                phase++;
                if (phase == lat + 1) begin
                    if (!is_d) exp_if = mem_read(cap_addr);
                    else if (!cap_we) exp_d = mem_read(cap_addr);
                end
            end
            @(negedge clk);
        end
        if_req[idx] = 1'b0;
        d_req[idx]  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            if_req[i] = 1'b0; if_addr[i] = '0;
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
            k_cnt[i] = 0; k_act[i] = 1'b0;
        end
        reset = 1'b1;
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_reset_mid();
        test_addr_change();
        test_random(0, 400);
        test_random(1, 400);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
